// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// The optional round-robin arbitration is enabled with the macro WBARB_RR_EN.
package wb_pkg;

    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int NREG    = 1 << RAW;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef struct packed {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic logic [NREG-1:0] rd_onehot(input logic [RAW-1:0] rd);
        logic [NREG-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of writeback requests; exposes per-entry valid/rd
// so the parent can build the pending-register mask from registered state.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  wb_req_t                   i_req,
    input  logic                      i_pop,
    output logic                      o_full,
    output logic                      o_empty,
    output wb_req_t                   o_head,
    output logic [DEPTH-1:0]          o_ent_vld,
    output logic [DEPTH-1:0][RAW-1:0] o_ent_rd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    wb_req_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [DEPTH-1:0] r_vld;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_ent_vld = r_vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_rd[i] = r_mem[i].rd;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_req;
        end
    end

    // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr        <= r_rd_ptr + 1'b1;
                r_vld[r_rd_ptr] <= 1'b0;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the ALU and load writeback paths onto the single register-file write port.
// Define WBARB_RR_EN for round-robin arbitration; default is fixed priority mem > alu.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RAW-1:0]  alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [RAW-1:0]  mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            w_en,
    output logic [RAW-1:0]  wd,
    output logic [XLEN-1:0] wdata,
    output logic [NREG-1:0] pending
);

    logic                      r_ready_en;
    logic                      r_wen;
    logic [RAW-1:0]            r_wd;
    logic [XLEN-1:0]           r_wdata;

    logic [1:0]                w_full;
    logic [1:0]                w_empty;
    logic [1:0]                w_push;
    logic [1:0]                w_grant;
    wb_req_t                   w_head [2];
    wb_req_t                   w_sel;
    logic [DEPTH-1:0]          w_alu_vld;
    logic [DEPTH-1:0]          w_mem_vld;
    logic [DEPTH-1:0][RAW-1:0] w_alu_ent_rd;
    logic [DEPTH-1:0][RAW-1:0] w_mem_ent_rd;
    logic [NREG-1:0]           w_pending;

    // Handshake: a transfer happens on a rising edge with x_valid && x_ready. x_ready is
    // a function of registered FIFO occupancy only, so there is no valid->ready path.
    // Transfers to x0 complete the handshake but are dropped instead of enqueued.
    assign alu_ready = r_ready_en & ~w_full[REQ_ALU];
    assign mem_ready = r_ready_en & ~w_full[REQ_MEM];

    assign w_push[REQ_ALU] = alu_valid & alu_ready & (alu_rd != '0);
    assign w_push[REQ_MEM] = mem_valid & mem_ready & (mem_rd != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push[REQ_ALU]),
        .i_req     ('{rd: alu_rd, data: alu_data}),
        .i_pop     (w_grant[REQ_ALU]),
        .o_full    (w_full[REQ_ALU]),
        .o_empty   (w_empty[REQ_ALU]),
        .o_head    (w_head[REQ_ALU]),
        .o_ent_vld (w_alu_vld),
        .o_ent_rd  (w_alu_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push[REQ_MEM]),
        .i_req     ('{rd: mem_rd, data: mem_data}),
        .i_pop     (w_grant[REQ_MEM]),
        .o_full    (w_full[REQ_MEM]),
        .o_empty   (w_empty[REQ_MEM]),
        .o_head    (w_head[REQ_MEM]),
        .o_ent_vld (w_mem_vld),
        .o_ent_rd  (w_mem_ent_rd)
    );

`ifdef WBARB_RR_EN
    logic r_prio_alu;
    logic w_contend;

    assign w_contend = ~w_empty[REQ_ALU] & ~w_empty[REQ_MEM];

    always_comb begin
        w_grant = '0;
        if (w_contend) begin
            if (r_prio_alu) w_grant[REQ_ALU] = 1'b1;
            else            w_grant[REQ_MEM] = 1'b1;
        end else if (!w_empty[REQ_MEM]) begin
            w_grant[REQ_MEM] = 1'b1;
        end else if (!w_empty[REQ_ALU]) begin
            w_grant[REQ_ALU] = 1'b1;
        end
    end

    // The preference flips only when both requesters actually competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_alu <= 1'b0;
        end else if (w_contend) begin
            r_prio_alu <= ~r_prio_alu;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        if (!w_empty[REQ_MEM]) begin
            w_grant[REQ_MEM] = 1'b1;
        end else if (!w_empty[REQ_ALU]) begin
            w_grant[REQ_ALU] = 1'b1;
        end
    end
`endif

    assign w_sel = w_grant[REQ_MEM] ? w_head[REQ_MEM] : w_head[REQ_ALU];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_wen      <= 1'b0;
            r_wd       <= '0;
            r_wdata    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_wen      <= |w_grant;
            if (|w_grant) begin
                r_wd    <= w_sel.rd;
                r_wdata <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_vld[i]) w_pending = w_pending | rd_onehot(w_alu_ent_rd[i]);
            if (w_mem_vld[i]) w_pending = w_pending | rd_onehot(w_mem_ent_rd[i]);
        end
        if (r_wen) w_pending = w_pending | rd_onehot(r_wd);
        w_pending[0] = 1'b0;
    end

    assign w_en    = r_wen;
    assign wd      = r_wd;
    assign wdata   = r_wdata;
    assign pending = w_pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single write, contention, back-pressure,
// x0 drop, streaming throughput and mid-stream reset.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [RAW-1:0]  alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [RAW-1:0]  mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            w_en;
    logic [RAW-1:0]  wd;
    logic [XLEN-1:0] wdata;
    logic [NREG-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .w_en      (w_en),
        .wd        (wd),
        .wdata     (wdata),
        .pending   (pending)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_errors++; $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); end
        n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL reset_w_en: got %0b want 0", w_en); end
        n_checks++; if (wd !== '0) begin n_errors++; $display("FAIL reset_wd: got %0d want 0", wd); end
        n_checks++; if (wdata !== '0) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL release_alu_ready: got %0b want 1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL release_mem_ready: got %0b want 1", mem_ready); end
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        tick();
        drive_idle();
        n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL single_early_w_en: got %0b want 0", w_en); end
        n_checks++; if (pending !== 32'h0000_0020) begin n_errors++; $display("FAIL single_pending_buf: got %h want 00000020", pending); end
        tick();
        n_checks++; if (w_en !== 1'b1) begin n_errors++; $display("FAIL single_w_en: got %0b want 1", w_en); end
        n_checks++; if (wd !== 5'd5) begin n_errors++; $display("FAIL single_wd: got %0d want 5", wd); end
        n_checks++; if (wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wdata: got %h want deadbeef", wdata); end
        n_checks++; if (pending !== 32'h0000_0020) begin n_errors++; $display("FAIL single_pending_out: got %h want 00000020", pending); end
        tick();
        n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL single_w_en_drop: got %0b want 0", w_en); end
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL single_pending_clear: got %h want 0", pending); end
        n_checks++; if (wd !== 5'd5) begin n_errors++; $display("FAIL single_wd_hold: got %0d want 5", wd); end
    endtask

    task automatic test_contention();
        logic [RAW-1:0] first_rd;
        logic [RAW-1:0] second_rd;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
        tick();
        drive_idle();
        n_checks++; if (pending !== 32'h0000_0088) begin n_errors++; $display("FAIL cont_pending: got %h want 00000088", pending); end
        tick();
        n_checks++; if ({w_en, wd, wdata} !== {1'b1, 5'd3, 32'h11}) begin n_errors++; $display("FAIL cont_first: got en=%0b rd=%0d data=%h want en=1 rd=3 data=11", w_en, wd, wdata); end
        n_checks++; if (pending !== 32'h0000_0088) begin n_errors++; $display("FAIL cont_pending_mid: got %h want 00000088", pending); end
        tick();
        n_checks++; if ({w_en, wd, wdata} !== {1'b1, 5'd7, 32'h22}) begin n_errors++; $display("FAIL cont_second: got en=%0b rd=%0d data=%h want en=1 rd=7 data=22", w_en, wd, wdata); end
        n_checks++; if (pending !== 32'h0000_0080) begin n_errors++; $display("FAIL cont_pending_end: got %h want 00000080", pending); end
        tick();
        n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL cont_idle: got %0b want 0", w_en); end
`ifdef WBARB_RR_EN
        first_rd = 5'd10; second_rd = 5'd9;
`else
        first_rd = 5'd9;  second_rd = 5'd10;
`endif
        mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h44;
        tick();
        drive_idle();
        tick();
        n_checks++; if ({w_en, wd} !== {1'b1, first_rd}) begin n_errors++; $display("FAIL cont2_first: got en=%0b rd=%0d want en=1 rd=%0d", w_en, wd, first_rd); end
        tick();
        n_checks++; if ({w_en, wd} !== {1'b1, second_rd}) begin n_errors++; $display("FAIL cont2_second: got en=%0b rd=%0d want en=1 rd=%0d", w_en, wd, second_rd); end
        tick();
    endtask

    task automatic test_x0_drop();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready: got %0b want 1", mem_ready); end
        tick();
        drive_idle();
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL x0_pending: got %h want 0", pending); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL x0_w_en cycle %0d: got %0b want 0", i, w_en); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [RAW+XLEN-1:0] exp_q[$];
        logic [RAW+XLEN-1:0] exp;
        int   mem_sent = 0;
        int   alu_sent = 0;
        logic mem_x;
        logic alu_x;
        // mem keeps its FIFO busy, so all four loads drain before any ALU write.
        for (int i = 0; i < 4; i++) exp_q.push_back({RAW'(i + 1), 32'(32'h1000 + i)});
        for (int i = 0; i < 3; i++) exp_q.push_back({RAW'(i + 11), 32'(32'h2000 + i)});
        for (int cyc = 1; cyc <= 14; cyc++) begin
            mem_valid = (mem_sent < 4);
            mem_rd    = RAW'(mem_sent + 1);
            mem_data  = 32'(32'h1000 + mem_sent);
            alu_valid = (alu_sent < 3);
            alu_rd    = RAW'(alu_sent + 11);
            alu_data  = 32'(32'h2000 + alu_sent);
            mem_x     = mem_valid && mem_ready;
            alu_x     = alu_valid && alu_ready;
            tick();
            mem_sent += int'(mem_x);
            alu_sent += int'(alu_x);
            if (cyc >= 2 && cyc <= 5) begin
                n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready cyc %0d: got %0b want 0", cyc, alu_ready); end
            end
            if (cyc == 6) begin
                n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL bp_reopen_ready: got %0b want 1", alu_ready); end
            end
            if (w_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL bp_extra_write: got rd=%0d data=%h want none", wd, wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({wd, wdata} !== exp) begin n_errors++; $display("FAIL bp_order: got rd=%0d data=%h want rd=%0d data=%h", wd, wdata, exp[RAW+XLEN-1:XLEN], exp[XLEN-1:0]); end
                end
            end
        end
        drive_idle();
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL bp_lost: got %0d writes missing want 0", exp_q.size()); end
        n_checks++; if (alu_sent != 3 || mem_sent != 4) begin n_errors++; $display("FAIL bp_sent: got alu=%0d mem=%0d want alu=3 mem=4", alu_sent, mem_sent); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            alu_valid = (i < 10);
            alu_rd    = RAW'(i + 1);
            alu_data  = 32'(32'hA000_0000 + i);
            n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready cyc %0d: got %0b want 1", i, alu_ready); end
            tick();
            if (i >= 1 && i <= 10) begin
                n_checks++;
                if ({w_en, wd, wdata} !== {1'b1, RAW'(i), 32'(32'hA000_0000 + i - 1)}) begin
                    n_errors++; $display("FAIL b2b_write cyc %0d: got en=%0b rd=%0d data=%h want en=1 rd=%0d data=%h", i, w_en, wd, wdata, i, 32'(32'hA000_0000 + i - 1));
                end
            end else begin
                n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL b2b_idle cyc %0d: got %0b want 0", i, w_en); end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h5555;
        mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h6666;
        tick();
        drive_idle();
        n_checks++; if (pending !== 32'h0030_0000) begin n_errors++; $display("FAIL rmid_pending_pre: got %h want 00300000", pending); end
        tick();
        n_checks++; if ({w_en, wd} !== {1'b1, 5'd21}) begin n_errors++; $display("FAIL rmid_inflight: got en=%0b rd=%0d want en=1 rd=21", w_en, wd); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (w_en !== 1'b0) begin n_errors++; $display("FAIL rmid_w_en: got %0b want 0", w_en); end
        n_checks++; if (wd !== '0) begin n_errors++; $display("FAIL rmid_wd: got %0d want 0", wd); end
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL rmid_pending: got %h want 0", pending); end
        n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_ready: got %0b want 0", alu_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({alu_ready, mem_ready} !== 2'b11) begin n_errors++; $display("FAIL rmid_release_ready: got %b want 11", {alu_ready, mem_ready}); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (w_en !== 1'b0 || pending !== '0) begin n_errors++; $display("FAIL rmid_no_write cyc %0d: got en=%0b pending=%h want en=0 pending=0", i, w_en, pending); end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_x0_drop();
`ifndef WBARB_RR_EN
        test_backpressure();
`endif
        tick();
        test_back_to_back();
        tick();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
